// File: rtl/clk_div_pkg.sv
// Shared defaults, channel-mode encoding and divisor helpers for the
// multi-channel clock divider.
package clk_div_pkg;

   localparam int          DIV_W_DEF   = 32;
   localparam int unsigned DEF_DIV_DEF = 100000000;
   // Helpers work at this width; DIV_W must not exceed it.
   localparam int          MAX_DIV_W   = 64;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_PASS = 2'd1,
      MODE_DIV  = 2'd2
   } chan_mode_e;

   function automatic logic [MAX_DIV_W-1:0] ceil_half(input logic [MAX_DIV_W-1:0] d);
      return (d >> 1) + {{(MAX_DIV_W-1){1'b0}}, d[0]};
   endfunction

   function automatic chan_mode_e div_mode(input logic [MAX_DIV_W-1:0] d);
      if (d == '0)
         return MODE_OFF;
      else if (d == MAX_DIV_W'(1))
         return MODE_PASS;
      else
         return MODE_DIV;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor with pending flag,
// and registered outclk/tick computed from the next-state values.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int               DIV_W   = DIV_W_DEF,
   parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_DIV_DEF)
) (
   input  logic             inclk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             sync,
   output logic             pending,
   output logic             outclk,
   output logic             tick
);

   logic [DIV_W-1:0] cnt, active_div, shadow_div;
   logic [DIV_W-1:0] cnt_nxt, active_nxt, shadow_nxt;
   logic             pending_nxt, outclk_nxt, tick_nxt;
   logic             period_end, apply;
   chan_mode_e       mode_cur, mode_nxt;

   always_comb begin
      mode_cur    = div_mode(MAX_DIV_W'(active_div));
      period_end  = (mode_cur != MODE_DIV) || (cnt == active_div - DIV_W'(1));
      apply       = pending && (sync || period_end);
      active_nxt  = apply ? shadow_div : active_div;
      shadow_nxt  = wr_en ? wr_div : shadow_div;
      pending_nxt = wr_en ? 1'b1 : (apply ? 1'b0 : pending);
      mode_nxt    = div_mode(MAX_DIV_W'(active_nxt));

      // A fresh divisor always starts its first period at phase 0.
      if (sync || apply || mode_nxt != MODE_DIV || period_end)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + DIV_W'(1);

      outclk_nxt = (mode_nxt == MODE_DIV) &&
                   (cnt_nxt >= DIV_W'(ceil_half(MAX_DIV_W'(active_nxt))));
      tick_nxt   = (mode_nxt == MODE_PASS) ||
                   ((mode_nxt == MODE_DIV) && (cnt_nxt == active_nxt - DIV_W'(1)));
      if (sync) begin
         outclk_nxt = 1'b0;
         tick_nxt   = 1'b0;
      end
   end

   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         active_div <= DEF_DIV;
         shadow_div <= DEF_DIV;
         pending    <= 1'b0;
         outclk     <= 1'b0;
         tick       <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         active_div <= active_nxt;
         shadow_div <= shadow_nxt;
         pending    <= pending_nxt;
         outclk     <= outclk_nxt;
         tick       <= tick_nxt;
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / clock-enable generator with a
// valid/ready divisor reload port and a global phase-align pulse.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int          NUM_CH  = 4,
   parameter int          DIV_W   = DIV_W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_DEF,
   localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              inclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              sync_i,
   output logic [NUM_CH-1:0] outclk,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] pending;

   // Indices with no channel behind them stay ready so writes are swallowed.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i))
            cfg_ready = !pending[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clk_div_chan #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DIV_W'(DEF_DIV))
      ) u_chan (
         .inclk   (inclk),
         .rst_n   (rst_n),
         .wr_en   (cfg_valid && cfg_ready && (cfg_ch == CH_W'(g))),
         .wr_div  (cfg_div),
         .sync    (sync_i),
         .pending (pending[g]),
         .outclk  (outclk[g]),
         .tick    (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor
// compares them against the two divider instances.
module tb_clk_div_multi;

   logic        inclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_ch = '0;
   logic [31:0] cfg_div = '0;
   logic        sync_i = 1'b0;
   logic [3:0]  outclk, tick;

   logic        cfg2_valid = 1'b0;
   logic        cfg2_ready;
   logic [1:0]  cfg2_ch = '0;
   logic [7:0]  cfg2_div = '0;
   logic        sync2 = 1'b0;
   logic [2:0]  outclk2, tick2;

   clk_div_multi #(.NUM_CH(4), .DIV_W(32), .DEF_DIV(4)) u_dut (
      .inclk(inclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync_i(sync_i), .outclk(outclk), .tick(tick)
   );

   clk_div_multi #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(4)) u_dut2 (
      .inclk(inclk), .rst_n(rst_n), .cfg_valid(cfg2_valid), .cfg_ready(cfg2_ready),
      .cfg_ch(cfg2_ch), .cfg_div(cfg2_div), .sync_i(sync2), .outclk(outclk2), .tick(tick2)
   );

   always #5 inclk = ~inclk;

   int cyc = 0;
   always @(posedge inclk) cyc <= cyc + 1;

   typedef struct {
      int    c;
      int    kind;
      int    idx;
      logic  val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam int K_OUT = 0, K_TICK = 1, K_RDY = 2, K_OUT2 = 3, K_TICK2 = 4, K_RDY2 = 5;

   function automatic void push(int c, int kind, int idx, logic v, string nm);
      exp_t e;
      e.c = c; e.kind = kind; e.idx = idx; e.val = v; e.name = nm;
      sb.push_back(e);
   endfunction

   // Hand pattern for a channel restarted at phase 0 by sync at cycle base:
   // low ceil(d/2), high floor(d/2), tick on the last cycle of each period.
   function automatic void push_pat(int base, int dut, int ch, int d, int n, string tag);
      for (int k = 0; k < n; k++) begin
         logic o, t;
         o = (d >= 2) && ((k % d) >= (d + 1) / 2);
         t = (d == 1) ? (k >= 1) : ((d >= 2) && ((k % d) == d - 1));
         push(base + k, dut ? K_OUT2 : K_OUT, ch, o, $sformatf("%s_ch%0d_outclk_k%0d", tag, ch, k));
         push(base + k, dut ? K_TICK2 : K_TICK, ch, t, $sformatf("%s_ch%0d_tick_k%0d", tag, ch, k));
      end
   endfunction

   function automatic logic sample(int kind, int idx);
      case (kind)
         K_OUT:   return outclk[idx];
         K_TICK:  return tick[idx];
         K_RDY:   return cfg_ready;
         K_OUT2:  return outclk2[idx];
         K_TICK2: return tick2[idx];
         default: return cfg2_ready;
      endcase
   endfunction

   always @(negedge inclk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].c <= cyc) begin
            logic act;
            act = sample(sb[i].kind, sb[i].idx);
            n_cmp++;
            if (sb[i].c < cyc || act !== sb[i].val) begin
               n_bad++;
               $display("FAIL %s at cycle %0d: got %b, expected %b (due cycle %0d)",
                        sb[i].name, cyc, act, sb[i].val, sb[i].c);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge inclk);
      #1;
   endtask

   task automatic cfg_wr(input int ch, input int d);
      cfg_ch    = 2'(ch);
      cfg_div   = 32'(d);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, t, s3, u, s4, c5, r, z, z2;

      // Reset state
      repeat (3) step();
      for (int ch = 0; ch < 4; ch++) begin
         push(cyc, K_OUT, ch, 1'b0, $sformatf("rst_ch%0d_outclk", ch));
         push(cyc, K_TICK, ch, 1'b0, $sformatf("rst_ch%0d_tick", ch));
      end
      push(cyc, K_RDY, 0, 1'b1, "rst_ready");
      push(cyc, K_RDY2, 0, 1'b1, "rst_ready2");
      rst_n = 1'b1;
      r = cyc;
      push(r + 1, K_TICK, 0, 1'b0, "rel_tick_c2");
      push(r + 2, K_TICK, 0, 1'b0, "rel_tick_c3");
      push(r + 2, K_OUT, 0, 1'b1, "rel_outclk_c3");
      push(r + 3, K_TICK, 0, 1'b1, "rel_tick_c4");
      push(r + 4, K_TICK, 0, 1'b0, "rel_tick_c5");
      repeat (4) step();

      // 1: D=4,5,1,0 on ch0..3, aligned by sync
      cfg_wr(0, 4);
      cfg_wr(1, 5);
      cfg_wr(2, 1);
      cfg_wr(3, 0);
      sync_i = 1'b1;
      s = cyc + 1;
      push_pat(s, 0, 0, 4, 20, "t1");
      push_pat(s, 0, 1, 5, 20, "t1");
      push_pat(s, 0, 2, 1, 20, "t1");
      push_pat(s, 0, 3, 0, 20, "t1");
      step();
      sync_i = 1'b0;
      repeat (20) step();

      // 2: ch0 D=4 -> 6 written at cnt=1
      while (((cyc - s) % 4) != 1) step();
      t = cyc;
      cfg_ch = 2'd0; cfg_div = 32'd6; cfg_valid = 1'b1;
      push(t, K_RDY, 0, 1'b1, "t2_ready_before");
      push(t + 1, K_RDY, 0, 1'b0, "t2_ready_pend1");
      push(t + 2, K_RDY, 0, 1'b0, "t2_ready_pend2");
      push(t + 3, K_RDY, 0, 1'b1, "t2_ready_applied");
      push(t + 1, K_OUT, 0, 1'b1, "t2_old_outclk_cnt2");
      push(t + 1, K_TICK, 0, 1'b0, "t2_old_tick_cnt2");
      push(t + 2, K_OUT, 0, 1'b1, "t2_old_outclk_cnt3");
      push(t + 2, K_TICK, 0, 1'b1, "t2_old_tick_cnt3");
      s3 = t + 3;
      push_pat(s3, 0, 0, 6, 12, "t2");
      step();
      cfg_valid = 1'b0;
      repeat (15) step();

      // 3: second write while pending is refused; first value applied
      while (((cyc - s3) % 6) != 1) step();
      u = cyc;
      cfg_ch = 2'd0; cfg_div = 32'd3; cfg_valid = 1'b1;
      push(u, K_RDY, 0, 1'b1, "t3_ready_first");
      step();
      cfg_div = 32'd8;
      for (int k = 1; k <= 4; k++) push(u + k, K_RDY, 0, 1'b0, $sformatf("t3_ready_blocked_%0d", k));
      push(u + 5, K_RDY, 0, 1'b1, "t3_ready_free");
      push_pat(u + 5, 0, 0, 3, 9, "t3");
      repeat (3) step();
      cfg_valid = 1'b0;
      repeat (12) step();

      // 4: ch0 D=4, ch1 D=6 aligned by sync; ticks coincide every 12 cycles
      cfg_wr(0, 4);
      cfg_wr(1, 6);
      sync_i = 1'b1;
      s4 = cyc + 1;
      push_pat(s4, 0, 0, 4, 25, "t4");
      push_pat(s4, 0, 1, 6, 25, "t4");
      push(s4, K_TICK, 2, 1'b0, "t4_ch2_tick_sync");
      push(s4 + 1, K_TICK, 2, 1'b1, "t4_ch2_tick_after");
      step();
      sync_i = 1'b0;
      repeat (24) step();

      // 5: reset mid-period with an update pending on ch1
      while (((cyc - s4) % 12) != 1) step();
      cfg_wr(1, 2);
      c5 = cyc;
      rst_n = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
         push(c5, K_OUT, ch, 1'b0, $sformatf("t5_async_ch%0d_outclk", ch));
         push(c5, K_TICK, ch, 1'b0, $sformatf("t5_async_ch%0d_tick", ch));
      end
      push(c5, K_RDY, 0, 1'b1, "t5_pending_lost");
      repeat (2) step();
      rst_n = 1'b1;
      r = cyc;
      for (int ch = 0; ch < 4; ch++) begin
         push(r + 1, K_TICK, ch, 1'b0, $sformatf("t5_ch%0d_tick_c2", ch));
         push(r + 2, K_OUT, ch, 1'b1, $sformatf("t5_ch%0d_outclk_c3", ch));
         push(r + 3, K_TICK, ch, 1'b1, $sformatf("t5_ch%0d_tick_c4", ch));
      end
      repeat (6) step();

      // 6: out-of-range write ignored; D=2**DIV_W-1 on the narrow instance
      cfg2_ch = 2'd3; cfg2_div = 8'd2; cfg2_valid = 1'b1;
      push(cyc, K_RDY2, 0, 1'b1, "t6_oob_ready");
      step();
      cfg2_valid = 1'b0;
      cfg2_ch = 2'd0;
      push(cyc, K_RDY2, 0, 1'b1, "t6_ch0_not_pending");
      sync2 = 1'b1;
      z = cyc + 1;
      for (int ch = 0; ch < 3; ch++) push_pat(z, 1, ch, 4, 8, "t6_def");
      step();
      sync2 = 1'b0;
      repeat (8) step();

      cfg2_ch = 2'd0; cfg2_div = 8'd255; cfg2_valid = 1'b1;
      step();
      cfg2_valid = 1'b0;
      sync2 = 1'b1;
      z2 = cyc + 1;
      push(z2, K_TICK2, 0, 1'b0, "t6_max_tick_k0");
      push(z2 + 127, K_OUT2, 0, 1'b0, "t6_max_outclk_k127");
      push(z2 + 128, K_OUT2, 0, 1'b1, "t6_max_outclk_k128");
      push(z2 + 253, K_TICK2, 0, 1'b0, "t6_max_tick_k253");
      push(z2 + 254, K_OUT2, 0, 1'b1, "t6_max_outclk_k254");
      push(z2 + 254, K_TICK2, 0, 1'b1, "t6_max_tick_k254");
      push(z2 + 255, K_TICK2, 0, 1'b0, "t6_max_tick_k255");
      push(z2 + 255, K_OUT2, 0, 1'b0, "t6_max_outclk_k255");
      push(z2 + 509, K_TICK2, 0, 1'b1, "t6_max_tick_k509");
      push(z2 + 3, K_TICK2, 1, 1'b1, "t6_ch1_tick_k3");
      step();
      sync2 = 1'b0;

      for (int i = 0; i < 1000 && sb.size() > 0; i++) step();
      repeat (2) step();
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations never reached, required 0", sb.size());
         n_bad += sb.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
